sme_param_engine: RTL and testbench
===================================

// Module: sme_param_engine
// PURPOSE
//  Parametrised string-matching engine; next generation of the fixed 32x8 SME.
//  Host streams a string, then one or more patterns, on a shared char bus.
//  After each pattern the engine scans every start position and reports:
//    - match / no-match
//    - first match index
//    - total match count (new in this generation)
//  It also drives a busy flag and has configurable depths.
// PARAMETERS
//  CHAR_W   8   character width (bits)
//  STR_MAX  32  max stored string length; extra chars are dropped
//  PAT_MAX  8   max stored pattern length incl. anchors; extra chars are dropped
//  IDX_W    $clog2(STR_MAX)    width of match_index
//  CNT_W    $clog2(STR_MAX+1)  width of match_count
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       asynchronous, active-low reset (0 = reset)
//  chardata     in   CHAR_W  character on the char bus
//  isstring     in   1       chardata is a string char this cycle
//  ispattern    in   1       chardata is a pattern char this cycle
//  busy         out  1       engine is searching; inputs ignored
//  valid        out  1       one-cycle result strobe
//  match        out  1       pattern found; qualified by valid
//  match_index  out  IDX_W   first matching start index; qualified by valid
//  match_count  out  CNT_W   number of matching start positions; qualified by valid
// BEHAVIOUR
//  Reset (reset=0):
//    - all outputs 0; FSM to IDLE
//    - stored string and pattern lengths cleared to 0
//    - this applies mid-load and mid-search alike; any result in flight is lost
//  FSM states: IDLE, LOAD_STR, LOAD_PAT, SEARCH, DONE.
//  IDLE
//    - isstring=1: clear str_len, store char at index 0, go to LOAD_STR
//    - else ispattern=1: clear pat_len, store char, go to LOAD_PAT
//  LOAD_STR
//    - isstring=1: append char if str_len<STR_MAX
//    - isstring=0: go to IDLE, or take the IDLE ispattern action this same cycle
//  LOAD_PAT
//    - ispattern=1: append char if pat_len<PAT_MAX
//    - ispattern=0: go to SEARCH with scan position p=0
//  isstring and ispattern both 1 in one cycle: isstring wins; the pattern char is dropped
//  String persists across patterns; a new isstring burst replaces it entirely
//  Pattern syntax:
//    - '^' (0x5E) as first pattern char: anchor; p==0 or str[p-1]==0x20
//    - '$' (0x24) as last pattern char: anchor; p+L==str_len or str[p+L]==0x20
//    - '.' (0x2E): matches any single char
//    - any other char: exact match
//    - '^' or '$' in any other position is a literal
//  Body = pattern minus anchors, length L. Position p matches iff:
//    - p+L <= str_len
//    - every body char matches str[p+i]
//    - every present anchor holds
//  SEARCH
//    - one start position per cycle; all L compares done in parallel
//    - busy=1
//    - runs exactly str_len cycles (p = 0..str_len-1) with no early exit
//    - then go to DONE
//    - if str_len==0 or L==0: go straight to DONE with match=0
//  DONE (one cycle)
//    - valid=1; match=(count>0)
//    - match_index = lowest matching p, else 0
//    - match_count = count, saturating at STR_MAX
//    - go to IDLE
//  Latency: valid rises str_len+1 clk edges after the first cycle with ispattern=0
//    (1 edge when str_len==0). busy=1 for those cycles.
//  Inputs seen while busy or valid are ignored.
//  All outputs registered; valid/match/index/count change only at the DONE edge and
//    hold until the next DONE or reset (valid returns to 0 after one cycle).
// TESTING
//  Setup: STR_MAX=32; string "hello world" (11 chars) for every pattern below.
//  1 pattern "o" -> valid=1 exactly 12 cycles after ispattern falls;
//    match=1, index=4, count=2
//  2 "^wor" -> match=1, index=6, count=1
//    "ld$" -> match=1, index=9, count=1
//    "^orld" -> match=0, count=0
//  3 "h.l" -> match=1, index=0, count=1
//    "xyz" -> match=0, index=0, count=0
//    "l" -> count=3, index=2
//  4 40-char string "aaaa..." then pattern "a" -> count=32, index=0
//    then 12-char pattern -> only first 8 chars used
//  5 reset driven 0 for 1 cycle mid-SEARCH -> no valid pulse; all outputs 0
//    then pattern "a" with no new string -> valid with match=0 (empty string)
//  6 isstring and ispattern both 1 on one cycle -> char stored in the string only
//    pattern sent while busy -> ignored; exactly one valid per accepted pattern

Source files
------------

// File: rtl/sme_param_engine.sv
// Parametrised string-matching engine: stores a string, then scans it once per
// pattern and reports match, first match index and match count.
module sme_param_engine #(
    parameter int unsigned CHAR_W  = 8,
    parameter int unsigned STR_MAX = 32,
    parameter int unsigned PAT_MAX = 8,
    parameter int unsigned IDX_W   = $clog2(STR_MAX),
    parameter int unsigned CNT_W   = $clog2(STR_MAX + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CHAR_W-1:0] chardata,
    input  logic              isstring,
    input  logic              ispattern,
    output logic              busy,
    output logic              valid,
    output logic              match,
    output logic [IDX_W-1:0]  match_index,
    output logic [CNT_W-1:0]  match_count
);

    localparam int unsigned PL_W = $clog2(PAT_MAX + 1);
    localparam int unsigned PA_W = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;
    localparam int unsigned SW   = $clog2(STR_MAX + PAT_MAX + 2) + 1;

    localparam logic [CHAR_W-1:0] CH_CARET  = CHAR_W'(8'h5E);
    localparam logic [CHAR_W-1:0] CH_DOLLAR = CHAR_W'(8'h24);
    localparam logic [CHAR_W-1:0] CH_DOT    = CHAR_W'(8'h2E);
    localparam logic [CHAR_W-1:0] CH_SPACE  = CHAR_W'(8'h20);

    typedef enum logic [2:0] {IDLE, LOAD_STR, LOAD_PAT, SEARCH, DONE} state_t;

    state_t state, state_d;

    logic [CHAR_W-1:0] str_mem [STR_MAX];
    logic [CHAR_W-1:0] pat_mem [PAT_MAX];

    logic [CNT_W-1:0] str_len, str_len_d;
    logic [PL_W-1:0]  pat_len, pat_len_d;
    logic             str_we, pat_we;
    logic [IDX_W-1:0] str_waddr;
    logic [PA_W-1:0]  pat_waddr;

    logic [CNT_W-1:0] p, p_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [IDX_W-1:0] first, first_d;
    logic             found, found_d;

    logic             busy_d, valid_d, match_d;
    logic [IDX_W-1:0] index_d;
    logic [CNT_W-1:0] count_d;

    logic             a_start, a_end;
    logic [PL_W-1:0]  body_len;
    logic             pos_hit;

    // Character storage carries no reset; lengths define what is valid.
    always_ff @(posedge clk) begin
        if (str_we) str_mem[str_waddr] <= chardata;
        if (pat_we) pat_mem[pat_waddr] <= chardata;
    end

    // Anchor decode and body length from the stored pattern.
    always_comb begin
        a_start  = (pat_len != '0) && (pat_mem[0] == CH_CARET);
        a_end    = (pat_len != '0) && (pat_mem[PA_W'(pat_len - PL_W'(1))] == CH_DOLLAR);
        body_len = pat_len - PL_W'(a_start) - PL_W'(a_end);
    end

    // Evaluate start position p against every body char in parallel.
    always_comb begin
        pos_hit = 1'b1;
        if (SW'(p) + SW'(body_len) > SW'(str_len)) pos_hit = 1'b0;
        for (int i = 0; i < PAT_MAX; i++) begin
            if (SW'(i) < SW'(body_len)) begin
                if (pat_mem[PA_W'(SW'(i) + SW'(a_start))] != CH_DOT &&
                    pat_mem[PA_W'(SW'(i) + SW'(a_start))] != str_mem[IDX_W'(SW'(p) + SW'(i))])
                    pos_hit = 1'b0;
            end
        end
        if (a_start && p != '0 && str_mem[IDX_W'(SW'(p) - SW'(1))] != CH_SPACE)
            pos_hit = 1'b0;
        if (a_end && (SW'(p) + SW'(body_len) < SW'(str_len)) &&
            str_mem[IDX_W'(SW'(p) + SW'(body_len))] != CH_SPACE)
            pos_hit = 1'b0;
    end

    // Next-state, datapath and output decisions.
    always_comb begin
        state_d   = state;
        str_len_d = str_len;
        pat_len_d = pat_len;
        str_we    = 1'b0;
        pat_we    = 1'b0;
        str_waddr = IDX_W'(str_len);
        pat_waddr = PA_W'(pat_len);
        p_d       = p;
        cnt_d     = cnt;
        first_d   = first;
        found_d   = found;
        busy_d    = 1'b0;
        valid_d   = 1'b0;
        match_d   = match;
        index_d   = match_index;
        count_d   = match_count;

        case (state)
            IDLE, LOAD_STR: begin
                if (isstring) begin
                    if (state == IDLE) begin
                        str_we    = 1'b1;
                        str_waddr = '0;
                        str_len_d = CNT_W'(1);
                        state_d   = LOAD_STR;
                    end else if (SW'(str_len) < SW'(STR_MAX)) begin
                        str_we    = 1'b1;
                        str_len_d = str_len + CNT_W'(1);
                    end
                end else if (ispattern) begin
                    pat_we    = 1'b1;
                    pat_waddr = '0;
                    pat_len_d = PL_W'(1);
                    state_d   = LOAD_PAT;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD_PAT: begin
                if (ispattern && !isstring) begin
                    if (SW'(pat_len) < SW'(PAT_MAX)) begin
                        pat_we    = 1'b1;
                        pat_len_d = pat_len + PL_W'(1);
                    end
                end else begin
                    p_d     = '0;
                    cnt_d   = '0;
                    first_d = '0;
                    found_d = 1'b0;
                    if (str_len == '0 || body_len == '0) begin
                        state_d = DONE;
                        valid_d = 1'b1;
                        match_d = 1'b0;
                        index_d = '0;
                        count_d = '0;
                    end else begin
                        state_d = SEARCH;
                        busy_d  = 1'b1;
                    end
                end
            end
            SEARCH: begin
                busy_d = 1'b1;
                if (pos_hit) begin
                    if (SW'(cnt) < SW'(STR_MAX)) cnt_d = cnt + CNT_W'(1);
                    if (!found) begin
                        found_d = 1'b1;
                        first_d = IDX_W'(p);
                    end
                end
                p_d = p + CNT_W'(1);
                if (p == str_len - CNT_W'(1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    match_d = found_d;
                    index_d = found_d ? first_d : '0;
                    count_d = cnt_d;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, control and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            str_len     <= '0;
            pat_len     <= '0;
            p           <= '0;
            cnt         <= '0;
            first       <= '0;
            found       <= 1'b0;
            busy        <= 1'b0;
            valid       <= 1'b0;
            match       <= 1'b0;
            match_index <= '0;
            match_count <= '0;
        end else begin
            state       <= state_d;
            str_len     <= str_len_d;
            pat_len     <= pat_len_d;
            p           <= p_d;
            cnt         <= cnt_d;
            first       <= first_d;
            found       <= found_d;
            busy        <= busy_d;
            valid       <= valid_d;
            match       <= match_d;
            match_index <= index_d;
            match_count <= count_d;
        end
    end

endmodule

// File: tb/tb_sme_param_engine.sv
// Directed self-checking bench for sme_param_engine with hand-computed results.
module tb_sme_param_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] chardata = '0;
    logic       isstring = 1'b0;
    logic       ispattern = 1'b0;
    logic       busy, valid, match;
    logic [4:0] match_index;
    logic [5:0] match_count;

    int checks = 0;
    int errors = 0;

    int         lat;
    logic       r_match, r_vafter;
    logic [4:0] r_idx;
    logic [5:0] r_cnt;
    bit         r_got;

    sme_param_engine dut (
        .clk(clk), .reset(reset), .chardata(chardata), .isstring(isstring),
        .ispattern(ispattern), .busy(busy), .valid(valid), .match(match),
        .match_index(match_index), .match_count(match_count)
    );

    always #5 clk = ~clk;

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            chardata = s[i];
            isstring = 1'b1;
            @(posedge clk); #1;
        end
        isstring = 1'b0;
        chardata = '0;
        @(posedge clk); #1;
    endtask

    task automatic send_pat(input string s);
        for (int i = 0; i < s.len(); i++) begin
            chardata  = s[i];
            ispattern = 1'b1;
            @(posedge clk); #1;
        end
        ispattern = 1'b0;
        chardata  = '0;
    endtask

    // Waits (bounded) for the result strobe, then steps past the DONE cycle.
    task automatic wait_result();
        lat   = 0;
        r_got = 0;
        for (int k = 0; k < 200 && !r_got; k++) begin
            @(posedge clk); #1;
            lat++;
            if (valid === 1'b1) r_got = 1;
        end
        r_match = match;
        r_idx   = match_index;
        r_cnt   = match_count;
        @(posedge clk); #1;
        r_vafter = valid;
    endtask

    task automatic run_pat(input string s);
        send_pat(s);
        wait_result();
        checks++;
        if (!r_got) begin
            errors++;
            $display("FAIL %s timeout: valid never rose", s);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, valid, match, match_index, match_count} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0", {busy, valid, match, match_index, match_count});
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset valid=%b busy=%b want 0 0", valid, busy);
        end
    endtask

    task automatic test_basic();
        send_str("hello world");
        run_pat("o");
        checks++;
        if (lat !== 12) begin errors++; $display("FAIL o_latency got %0d want 12", lat); end
        checks++;
        if (r_match !== 1'b1 || r_idx !== 5'd4 || r_cnt !== 6'd2) begin
            errors++;
            $display("FAIL o_result got m=%b i=%0d c=%0d want 1 4 2", r_match, r_idx, r_cnt);
        end
        checks++;
        if (r_vafter !== 1'b0) begin errors++; $display("FAIL o_valid_pulse got %b want 0", r_vafter); end
    endtask

    task automatic test_anchors();
        run_pat("^wor");
        checks++;
        if (r_match !== 1'b1 || r_idx !== 5'd6 || r_cnt !== 6'd1) begin
            errors++;
            $display("FAIL caret_wor got m=%b i=%0d c=%0d want 1 6 1", r_match, r_idx, r_cnt);
        end
        run_pat("ld$");
        checks++;
        if (r_match !== 1'b1 || r_idx !== 5'd9 || r_cnt !== 6'd1) begin
            errors++;
            $display("FAIL ld_dollar got m=%b i=%0d c=%0d want 1 9 1", r_match, r_idx, r_cnt);
        end
        run_pat("^orld");
        checks++;
        if (r_match !== 1'b0 || r_cnt !== 6'd0) begin
            errors++;
            $display("FAIL caret_orld got m=%b c=%0d want 0 0", r_match, r_cnt);
        end
    endtask

    task automatic test_wildcard();
        run_pat("h.l");
        checks++;
        if (r_match !== 1'b1 || r_idx !== 5'd0 || r_cnt !== 6'd1) begin
            errors++;
            $display("FAIL h_dot_l got m=%b i=%0d c=%0d want 1 0 1", r_match, r_idx, r_cnt);
        end
        run_pat("xyz");
        checks++;
        if (r_match !== 1'b0 || r_idx !== 5'd0 || r_cnt !== 6'd0) begin
            errors++;
            $display("FAIL xyz got m=%b i=%0d c=%0d want 0 0 0", r_match, r_idx, r_cnt);
        end
        run_pat("l");
        checks++;
        if (r_match !== 1'b1 || r_idx !== 5'd2 || r_cnt !== 6'd3) begin
            errors++;
            $display("FAIL l_count got m=%b i=%0d c=%0d want 1 2 3", r_match, r_idx, r_cnt);
        end
    endtask

    task automatic test_saturate();
        string s;
        s = "";
        for (int i = 0; i < 40; i++) s = {s, "a"};
        send_str(s);
        run_pat("a");
        checks++;
        if (r_match !== 1'b1 || r_idx !== 5'd0 || r_cnt !== 6'd32) begin
            errors++;
            $display("FAIL sat_count got m=%b i=%0d c=%0d want 1 0 32", r_match, r_idx, r_cnt);
        end
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL sat_latency got %0d want 33", lat); end
        run_pat("aaaaaaaabbbb");
        checks++;
        if (r_match !== 1'b1 || r_idx !== 5'd0 || r_cnt !== 6'd25) begin
            errors++;
            $display("FAIL pat_trunc got m=%b i=%0d c=%0d want 1 0 25", r_match, r_idx, r_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int nvalid;
        send_str("hello world");
        send_pat("o");
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_search got %b want 1", busy); end
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        checks++;
        if ({busy, valid, match, match_index, match_count} !== 14'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs got %b want 0", {busy, valid, match, match_index, match_count});
        end
        nvalid = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (valid === 1'b1) nvalid++;
        end
        checks++;
        if (nvalid !== 0) begin errors++; $display("FAIL lost_result got %0d valids want 0", nvalid); end
        run_pat("a");
        checks++;
        if (lat !== 1 || r_match !== 1'b0 || r_idx !== 5'd0 || r_cnt !== 6'd0) begin
            errors++;
            $display("FAIL empty_string got lat=%0d m=%b i=%0d c=%0d want 1 0 0 0", lat, r_match, r_idx, r_cnt);
        end
    endtask

    task automatic test_collision();
        chardata = "x"; isstring = 1'b1;
        @(posedge clk); #1;
        chardata = "a"; ispattern = 1'b1;
        @(posedge clk); #1;
        isstring = 1'b0; ispattern = 1'b0; chardata = '0;
        @(posedge clk); #1;
        run_pat("a");
        checks++;
        if (r_match !== 1'b1 || r_idx !== 5'd1 || r_cnt !== 6'd1) begin
            errors++;
            $display("FAIL collision_a got m=%b i=%0d c=%0d want 1 1 1", r_match, r_idx, r_cnt);
        end
        run_pat("xa");
        checks++;
        if (r_match !== 1'b1 || r_idx !== 5'd0 || r_cnt !== 6'd1) begin
            errors++;
            $display("FAIL collision_xa got m=%b i=%0d c=%0d want 1 0 1", r_match, r_idx, r_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int nvalid;
        logic [4:0] fidx;
        logic [5:0] fcnt;
        send_str("hello world");
        send_pat("o");
        @(posedge clk); #1;
        ispattern = 1'b1; chardata = "h";
        repeat (4) begin @(posedge clk); #1; end
        ispattern = 1'b0; chardata = '0;
        nvalid = 0; fidx = '0; fcnt = '0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid === 1'b1) begin
                if (nvalid == 0) begin fidx = match_index; fcnt = match_count; end
                nvalid++;
            end
        end
        checks++;
        if (nvalid !== 1) begin errors++; $display("FAIL busy_ignore got %0d valids want 1", nvalid); end
        checks++;
        if (fidx !== 5'd4 || fcnt !== 6'd2) begin
            errors++;
            $display("FAIL busy_result got i=%0d c=%0d want 4 2", fidx, fcnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_anchors();
        test_wildcard();
        test_saturate();
        test_reset_mid();
        test_collision();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
